// File: rtl/uart_report_scheduler.sv
// Queues on-demand and periodic report requests as per-source pending flags and
// hands them to the UART sender one at a time, round-robin, as single-cycle pulses.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | no report in flight; picks next pending source, if any
// S_ISSUE      | registered request pulse for the granted source is high
// S_WAIT_START | waiting for the sender to raise busy (bounded by timeout)
// S_WAIT_DONE  | sender busy with the report; wait for it to drop
module uart_report_scheduler #(
   parameter int TICK_DIV      = 100000,
   parameter int PERIOD_MS     = 1000,
   parameter int START_TIMEOUT = 16
) (
   input  logic       iClk,
   input  logic       iRstn,
   input  logic       iAutoEn,
   input  logic       iCmdWatch,
   input  logic       iCmdSr04,
   input  logic       iCmdTemp,
   input  logic       iCmdHum,
   input  logic       iSr04DistanceValid,
   input  logic       iDhtDataValid,
   input  logic       iSenderBusy,
   output logic       oReqWatchReport,
   output logic       oReqSr04Report,
   output logic       oReqTempReport,
   output logic       oReqHumReport,
   output logic [3:0] oPending,
   output logic       oBusy
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int MW = $clog2(PERIOD_MS + 1);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MS_LAST    = MW'(PERIOD_MS - 1);
   localparam logic [TW-1:0] TMO_LOAD   = TW'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [MW-1:0]   ms_q, ms_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [3:0]      pend_q, pend_d;
   logic [3:0]      req_q, req_d;

   logic            auto_tick;
   logic [3:0]      set_vec;
   logic [3:0]      clr_vec;
   logic            grant_valid;
   logic [1:0]      grant_idx;
   logic [1:0]      cand;

   always_comb begin
      presc_d = presc_q;
      ms_d    = ms_q;
      if (!iAutoEn) begin
         presc_d = '0;
         ms_d    = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         ms_d    = (ms_q == MS_LAST) ? '0 : ms_q + MW'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   assign auto_tick = iAutoEn && (presc_q == PRESC_LAST) && (ms_q == MS_LAST);

   // Validity is sampled in the tick cycle itself; watch has no data to gate on.
   assign set_vec = {iCmdHum, iCmdTemp, iCmdSr04, iCmdWatch}
                  | ({iDhtDataValid, iDhtDataValid, iSr04DistanceValid, 1'b1} & {4{auto_tick}});

   // Descending scan so the lowest offset from the pointer is the one that sticks.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr_q;
      cand        = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr_q + 2'(i);
         if (pend_q[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tmo_d   = tmo_q;
      req_d   = 4'b0000;
      clr_vec = 4'b0000;
      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               state_d = S_ISSUE;
               ptr_d   = grant_idx + 2'd1;
               clr_vec = 4'b0001 << grant_idx;
               req_d   = 4'b0001 << grant_idx;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_START;
            tmo_d   = TMO_LOAD;
         end
         S_WAIT_START: begin
            if (iSenderBusy) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q == '0) begin
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!iSenderBusy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A same-cycle set overrides the grant clear so a fresh request is never lost.
   assign pend_d = (pend_q & ~clr_vec) | set_vec;

   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         ms_q    <= '0;
         tmo_q   <= '0;
         ptr_q   <= 2'd0;
         pend_q  <= 4'b0000;
         req_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         ms_q    <= ms_d;
         tmo_q   <= tmo_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
      end
   end

   assign oReqWatchReport = req_q[0];
   assign oReqSr04Report  = req_q[1];
   assign oReqTempReport  = req_q[2];
   assign oReqHumReport   = req_q[3];
   assign oPending        = pend_q;
   assign oBusy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Directed bench for uart_report_scheduler: vector table of command patterns plus
// hand-written sequences for auto period, coalescing, timeout and mid-report reset.
module tb_uart_report_scheduler;

   logic       clk = 1'b0;
   logic       rstn;
   logic       auto_en;
   logic [3:0] cmd;
   logic       sr04_valid;
   logic       dht_valid;
   logic       sender_busy;
   logic       req_watch, req_sr04, req_temp, req_hum;
   logic [3:0] pending;
   logic       busy;
   logic [3:0] req;

   int vectors = 0;
   int miscompares = 0;
   int viol = 0;
   int cyc = 0;
   bit sender_en = 1'b1;
   int sender_cnt = 0;

   always #5 clk = ~clk;

   uart_report_scheduler #(
      .TICK_DIV      (10),
      .PERIOD_MS     (5),
      .START_TIMEOUT (16)
   ) dut (
      .iClk               (clk),
      .iRstn              (rstn),
      .iAutoEn            (auto_en),
      .iCmdWatch          (cmd[0]),
      .iCmdSr04           (cmd[1]),
      .iCmdTemp           (cmd[2]),
      .iCmdHum            (cmd[3]),
      .iSr04DistanceValid (sr04_valid),
      .iDhtDataValid      (dht_valid),
      .iSenderBusy        (sender_busy),
      .oReqWatchReport    (req_watch),
      .oReqSr04Report     (req_sr04),
      .oReqTempReport     (req_temp),
      .oReqHumReport      (req_hum),
      .oPending           (pending),
      .oBusy              (busy)
   );

   assign req = {req_hum, req_temp, req_sr04, req_watch};

   // Sender: busy rises the cycle after a request and stays high 20 cycles.
   always @(posedge clk) begin
      if (!rstn)                    sender_cnt <= 0;
      else if (sender_en && (|req)) sender_cnt <= 20;
      else if (sender_cnt != 0)     sender_cnt <= sender_cnt - 1;
   end
   assign sender_busy = (sender_cnt != 0);

   always @(negedge clk) begin
      if (rstn) begin
         if ($countones(req) > 1) viol <= viol + 1;
         if ((|req) && !busy)     viol <= viol + 1;
      end
   end

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] req;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse(input logic [3:0] c);
      cmd = c;
      step();
      cmd = 4'b0000;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cmd = 4'b0000;
      auto_en = 1'b0;
      sr04_valid = 1'b0;
      dht_valid = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic wait_req(input int limit, output bit found, output logic [3:0] r,
                           output logic [3:0] p);
      found = 1'b0;
      r = 4'b0000;
      p = 4'b0000;
      for (int i = 0; i < limit; i++) begin
         step();
         if (|req) begin
            found = 1'b1;
            r = req;
            p = pending;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (!busy && pending == 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, int'(ok), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         found;
      logic [3:0] r, p;
      int         t_prev, nreq;
      logic [3:0] exp_seq_r [4];
      logic [3:0] exp_seq_p [4];
      int         exp_auto_k [4];
      logic [3:0] exp_auto_r [4];

      tbl[0] = '{cmd: 4'b0100, req: 4'b0100};
      tbl[1] = '{cmd: 4'b0001, req: 4'b0001};
      tbl[2] = '{cmd: 4'b1001, req: 4'b1000};
      tbl[3] = '{cmd: 4'b0011, req: 4'b0010};
      tbl[4] = '{cmd: 4'b1100, req: 4'b0100};
      tbl[5] = '{cmd: 4'b1110, req: 4'b0010};
      tbl[6] = '{cmd: 4'b0010, req: 4'b0010};
      tbl[7] = '{cmd: 4'b0001, req: 4'b0001};

      exp_seq_r[0] = 4'b0001; exp_seq_p[0] = 4'b1110;
      exp_seq_r[1] = 4'b0010; exp_seq_p[1] = 4'b1100;
      exp_seq_r[2] = 4'b0100; exp_seq_p[2] = 4'b1000;
      exp_seq_r[3] = 4'b1000; exp_seq_p[3] = 4'b0000;

      exp_auto_k[0] = 51;  exp_auto_r[0] = 4'b0001;
      exp_auto_k[1] = 74;  exp_auto_r[1] = 4'b0010;
      exp_auto_k[2] = 101; exp_auto_r[2] = 4'b0001;
      exp_auto_k[3] = 124; exp_auto_r[3] = 4'b0010;

      do_reset();
      chk("reset_pending", int'(pending), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_req", int'(req), 0);

      // All four at once: strict order, one busy window apart, pending draining.
      pulse(4'b1111);
      chk("all4_pend", int'(pending), 4'hf);
      step();
      chk("all4_req0", int'(req), int'(exp_seq_r[0]));
      chk("all4_pend0", int'(pending), int'(exp_seq_p[0]));
      t_prev = cyc;
      for (int k = 1; k < 4; k++) begin
         wait_req(40, found, r, p);
         chk("all4_found", int'(found), 1);
         chk("all4_req", int'(r), int'(exp_seq_r[k]));
         chk("all4_pend", int'(p), int'(exp_seq_p[k]));
         chk("all4_gap", cyc - t_prev, 23);
         t_prev = cyc;
      end
      wait_idle("all4_idle");

      for (int v = 0; v < 8; v++) begin
         pulse(tbl[v].cmd);
         chk($sformatf("vec%0d_pend", v), int'(pending), int'(tbl[v].cmd));
         step();
         chk($sformatf("vec%0d_req", v), int'(req), int'(tbl[v].req));
         chk($sformatf("vec%0d_pend_after", v), int'(pending), int'(tbl[v].cmd & ~tbl[v].req));
         step();
         chk($sformatf("vec%0d_req_off", v), int'(req), 0);
         wait_idle($sformatf("vec%0d_idle", v));
      end

      // Pointer lands on temp after sr04, so hum beats watch.
      pulse(4'b0010);
      step();
      chk("rr_sr04", int'(req), 4'b0010);
      step();
      pulse(4'b1001);
      wait_req(40, found, r, p);
      chk("rr_first_found", int'(found), 1);
      chk("rr_first_hum", int'(r), 4'b1000);
      wait_req(40, found, r, p);
      chk("rr_second_found", int'(found), 1);
      chk("rr_second_watch", int'(r), 4'b0001);
      wait_idle("rr_idle");

      // Auto period: ticks at 50 and 100 cycles after enable, watch+sr04 only.
      do_reset();
      sr04_valid = 1'b1;
      dht_valid = 1'b0;
      auto_en = 1'b1;
      nreq = 0;
      for (int k = 1; k <= 130; k++) begin
         step();
         if (k == 49)  chk("auto_pend_pre", int'(pending), 0);
         if (k == 50)  chk("auto_pend_t1", int'(pending), 4'b0011);
         if (k == 100) chk("auto_pend_t2", int'(pending), 4'b0011);
         if (|req) begin
            if (nreq < 4) begin
               chk("auto_req_cycle", k, exp_auto_k[nreq]);
               chk("auto_req_id", int'(req), int'(exp_auto_r[nreq]));
            end
            nreq++;
         end
      end
      chk("auto_req_count", nreq, 4);
      auto_en = 1'b0;
      sr04_valid = 1'b0;
      wait_idle("auto_idle");

      // Set wins over the grant clear; repeated pulses while pending coalesce.
      do_reset();
      cmd = 4'b1000;
      step();
      step();
      cmd = 4'b0000;
      chk("coal_req1", int'(req), 4'b1000);
      chk("coal_pend_kept", int'(pending), 4'b1000);
      t_prev = cyc;
      wait_req(40, found, r, p);
      chk("coal_req2_found", int'(found), 1);
      chk("coal_req2", int'(r), 4'b1000);
      chk("coal_req2_gap", cyc - t_prev, 23);
      t_prev = cyc;
      step();
      step();
      step();
      pulse(4'b1000);
      chk("coal_pend_hum", int'(pending), 4'b1000);
      step();
      pulse(4'b1000);
      wait_req(40, found, r, p);
      chk("coal_req3_found", int'(found), 1);
      chk("coal_req3_gap", cyc - t_prev, 23);
      nreq = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (|req) nreq++;
      end
      chk("coal_no_extra", nreq, 0);
      chk("coal_pend_empty", int'(pending), 0);

      // Sender never answers: grant abandoned after the start timeout.
      do_reset();
      sender_en = 1'b0;
      pulse(4'b0011);
      step();
      chk("tmo_req_watch", int'(req), 4'b0001);
      for (int j = 1; j <= 18; j++) begin
         step();
         if (j == 16) chk("tmo_busy_still", int'(busy), 1);
         if (j == 17) chk("tmo_back_idle", int'(busy), 0);
         if (j == 17) chk("tmo_no_requeue", int'(pending), 4'b0010);
         if (j == 18) chk("tmo_req_sr04", int'(req), 4'b0010);
      end
      wait_idle("tmo_idle");
      sender_en = 1'b1;

      // Reset while the sender is busy drops everything in flight.
      pulse(4'b0100);
      step();
      chk("rst_req_temp", int'(req), 4'b0100);
      step();
      step();
      step();
      pulse(4'b1000);
      chk("rst_pend_before", int'(pending), 4'b1000);
      chk("rst_busy_before", int'(busy), 1);
      rstn = 1'b0;
      step();
      chk("rst_pend_after", int'(pending), 0);
      chk("rst_busy_after", int'(busy), 0);
      chk("rst_req_after", int'(req), 0);
      rstn = 1'b1;
      nreq = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (|req) nreq++;
      end
      chk("rst_no_reqs", nreq, 0);

      chk("onehot_and_busy_rule", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_report_scheduler.md
Name: uart_report_scheduler

Overview:
Sequences report requests into the UART ASCII sender. It collects on-demand report commands from the command decoder and periodic auto-report ticks, and holds them as per-source pending flags. It grants them one at a time in round-robin order as single-cycle request pulses, and waits for the sender to finish each report before issuing the next. This prevents overlapping or dropped requests when several sources fire together.

Parameters:
TICK_DIV, 100000, clock cycles per 1 ms tick (100 MHz clock).
PERIOD_MS, 1000, auto-report period in ms ticks (>=1).
START_TIMEOUT, 16, cycles to wait for iSenderBusy to rise after a grant before abandoning it.

Ports:
iClk  in  1  system clock
iRstn  in  1  synchronous active-low reset
iAutoEn  in  1  periodic auto-report enable (level)
iCmdWatch  in  1  one-cycle command pulse: request watch report
iCmdSr04  in  1  one-cycle command pulse: request SR04 report
iCmdTemp  in  1  one-cycle command pulse: request temperature report
iCmdHum  in  1  one-cycle command pulse: request humidity report
iSr04DistanceValid  in  1  SR04 data valid (gates auto SR04)
iDhtDataValid  in  1  DHT11 data valid (gates auto temp/hum)
iSenderBusy  in  1  high while sender is emitting a report
oReqWatchReport  out  1  one-cycle request pulse to sender
oReqSr04Report  out  1  one-cycle request pulse to sender
oReqTempReport  out  1  one-cycle request pulse to sender
oReqHumReport  out  1  one-cycle request pulse to sender
oPending  out  4  pending flags {hum,temp,sr04,watch}
oBusy  out  1  high in any state other than IDLE

Behaviour:
- Reset (iRstn=0 at posedge): all oReq*=0, oPending=0, oBusy=0, FSM=IDLE, RR pointer=0, prescaler=0, ms counter=0.
- Source index: watch=0, sr04=1, temp=2, hum=3.
- Pending set:
  - A command pulse sets its bit on the next edge.
  - An auto tick sets bit0 always, bit1 if iSr04DistanceValid, and bits2/3 if iDhtDataValid.
  - Validity is sampled in the tick cycle.
  - Setting an already-set bit has no effect (requests coalesce, no counting).
- Pending clear: the granted bit clears on the edge that enters ISSUE. If a set and a clear of the same bit occur in the same cycle, the set wins and the bit stays 1.
- Auto timer:
  - The prescaler counts 0..TICK_DIV-1 and the ms counter counts 0..PERIOD_MS-1 while iAutoEn=1.
  - The auto tick fires for one cycle when both counters wrap, i.e. first tick TICK_DIV*PERIOD_MS cycles after iAutoEn rises.
  - iAutoEn=0 holds both counters at 0.
  - The timer runs independently of FSM state. A tick during a report only sets pending bits.
- Arbitration: in IDLE with oPending!=0, select the first set bit searching from RR pointer upward, modulo 4. On grant, pointer = granted index + 1 mod 4.
- FSM (states IDLE, ISSUE, WAIT_START, WAIT_DONE):
  - IDLE: if pending!=0, record grant index and go to ISSUE.
  - ISSUE: assert exactly the granted oReq* for this single cycle (registered output), then go to WAIT_START.
  - WAIT_START: count cycles. iSenderBusy=1 goes to WAIT_DONE. The count reaching START_TIMEOUT goes to IDLE; the grant is dropped, not re-queued.
  - WAIT_DONE: iSenderBusy=0 goes to IDLE.
- Latency: a command pulse in cycle N gives pending=1 in N+1 and the oReq pulse in N+2 when the FSM is idle.
- Minimum spacing between consecutive grants: 4 cycles (ISSUE, WAIT_START with busy seen, WAIT_DONE, IDLE).
- At most one oReq* is high in any cycle. oReq* is never high outside ISSUE.
- Reset mid-operation: immediate return to reset values. Any in-flight grant and all pending bits are lost.

Test Plan:
All scenarios use TICK_DIV=10, PERIOD_MS=5, START_TIMEOUT=16, with a sender model that raises busy 1 cycle after a req and holds it 20 cycles.

- Single command: pulse iCmdTemp, iAutoEn=0 -> oReqTempReport high exactly 1 cycle, 2 cycles after the pulse. oPending returns to 0. No other req.
- Simultaneous commands: pulse all four iCmd* in the same cycle from reset -> grants in order watch, sr04, temp, hum. Each req is separated by >= 22 cycles (one full busy window). oPending decrements 4'b1111 -> 1110 -> 1100 -> 1000 -> 0000.
- Round-robin fairness: grant sr04, then pulse iCmdWatch and iCmdHum together -> hum is granted before watch, because the pointer is 2.
- Auto period: iAutoEn=1, iSr04DistanceValid=1, iDhtDataValid=0 -> first tick at 50 cycles sets pending 4'b0011. Watch then sr04 are granted. The next tick at 100 cycles repeats.
- Coalesce/set-wins: re-pulse iCmdHum in the same cycle its grant enters ISSUE -> a second hum grant follows the first. Pulsing iCmdHum twice while hum is pending -> only one grant.
- Timeout and reset: sender never raises busy -> after a req, FSM returns to IDLE after 16 cycles and the next pending is granted. Asserting iRstn=0 during WAIT_DONE -> all outputs 0 on the next edge and no further reqs.
